// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, parity constants and parity helper for the UART receiver
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Widest legal word; narrower words are zero-extended before the call.
  localparam int MAX_DATA_W = 9;

  function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync_vote.sv
// rtl/uart_rx_sync_vote.sv - 2-flop line synchroniser plus 3-sample majority vote
module uart_rx_sync_vote (
  input  logic baud_clk,
  input  logic reset,
  input  logic data_tx,
  output logic rx_s,
  output logic vote
);

  logic sync_q1;
  logic sync_q2;
  logic hist_q1;
  logic hist_q2;

  // Everything presets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge baud_clk) begin
    if (reset) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      hist_q1 <= 1'b1;
      hist_q2 <= 1'b1;
    end else begin
      sync_q1 <= data_tx;
      sync_q2 <= sync_q1;
      hist_q1 <= sync_q2;
      hist_q2 <= hist_q1;
    end
  end

  assign rx_s = sync_q2;
  assign vote = (rx_s & hist_q1) | (rx_s & hist_q2) | (hist_q1 & hist_q2);

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised oversampling UART receiver with error flags and valid/ready output
module uart_rx_param #(
  parameter int DATA_W     = 8,
  parameter int OS         = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              baud_clk,
  input  logic              reset,
  input  logic              data_tx,
  input  logic              data_ready,
  output logic [DATA_W-1:0] data_parll,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun_err,
  output logic              active_flag
);

  import uart_pkg::*;

  localparam int TW = $clog2(OS);

  logic rx_s;
  logic vote;

  uart_rx_sync_vote u_sync_vote (
    .baud_clk (baud_clk),
    .reset    (reset),
    .data_tx  (data_tx),
    .rx_s     (rx_s),
    .vote     (vote)
  );

  rx_state_t         state, state_n;
  logic [TW-1:0]     tick_cnt, tick_n;
  logic [3:0]        bit_cnt, bit_n;
  logic              stop_cnt, stop_n;
  logic [DATA_W-1:0] shreg, sh_n;
  logic              perr_p, perr_n;
  logic              ferr_p, ferr_n;
  logic              complete;
  logic              comp_ferr;
  logic              sample;
  logic              exp_par;
  logic [MAX_DATA_W-1:0] par_vec;

  always_comb begin
    par_vec = '0;
    par_vec[DATA_W-1:0] = shreg;
  end

  assign exp_par = calc_parity(par_vec) ^
                   ((PARITY_ODD != 0) ? uart_pkg::PARITY_ODD : uart_pkg::PARITY_EVEN);
  assign sample  = (tick_cnt == TW'(OS - 1));

  always_comb begin
    state_n   = state;
    tick_n    = tick_cnt + 1'b1;
    bit_n     = bit_cnt;
    stop_n    = stop_cnt;
    sh_n      = shreg;
    perr_n    = perr_p;
    ferr_n    = ferr_p;
    complete  = 1'b0;
    comp_ferr = ferr_p;
    case (state)
      ST_IDLE: begin
        tick_n = '0;
        if (!rx_s) state_n = ST_START;
      end
      ST_START: begin
        if (tick_cnt == TW'(OS / 2 - 1)) begin
          if (vote) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_DATA;
            tick_n  = '0;
            bit_n   = '0;
            perr_n  = 1'b0;
            ferr_n  = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (sample) begin
          sh_n  = {vote, shreg[DATA_W-1:1]};
          bit_n = bit_cnt + 1'b1;
          if (bit_cnt == 4'(DATA_W - 1)) begin
            state_n = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            stop_n  = 1'b0;
          end
        end
      end
      ST_PARITY: begin
        if (sample) begin
          if (vote != exp_par) perr_n = 1'b1;
          state_n = ST_STOP;
          stop_n  = 1'b0;
        end
      end
      ST_STOP: begin
        if (sample) begin
          if (!vote) ferr_n = 1'b1;
          comp_ferr = ferr_p | ~vote;
          // Completing at mid-stop-bit leaves half a bit to catch a back-to-back start.
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            complete = 1'b1;
            state_n  = vote ? ST_IDLE : ST_BREAK;
          end else begin
            stop_n = stop_cnt + 1'b1;
          end
        end
      end
      ST_BREAK: begin
        tick_n = '0;
        if (rx_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge baud_clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
      shreg       <= '0;
      perr_p      <= 1'b0;
      ferr_p      <= 1'b0;
      active_flag <= 1'b0;
    end else begin
      state       <= state_n;
      tick_cnt    <= tick_n;
      bit_cnt     <= bit_n;
      stop_cnt    <= stop_n;
      shreg       <= sh_n;
      perr_p      <= perr_n;
      ferr_p      <= ferr_n;
      active_flag <= (state_n == ST_DATA) || (state_n == ST_PARITY) || (state_n == ST_STOP);
    end
  end

  // Output holding register: an unaccepted word is never overwritten.
  always_ff @(posedge baud_clk) begin
    if (reset) begin
      data_parll  <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (complete) begin
        if (!data_valid || data_ready) begin
          data_parll <= shreg;
          parity_err <= perr_p;
          frame_err  <= comp_ferr;
          data_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for uart_rx_param, default and 7-bit/odd/2-stop configurations
module tb_uart_rx_param;

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       baud_clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_a = 1'b1, tx_b = 1'b1;
  logic       ready_a = 1'b1, ready_b = 1'b1;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       valid_a, pe_a, fe_a, ovr_a, act_a;
  logic       valid_b, pe_b, fe_b, ovr_b, act_b;

  int vectors = 0;
  int errors = 0;
  int ovr_cnt_a = 0, ovr_cnt_b = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  always #5 baud_clk = ~baud_clk;

  uart_rx_param dut_a (
    .baud_clk(baud_clk), .reset(reset), .data_tx(tx_a), .data_ready(ready_a),
    .data_parll(data_a), .data_valid(valid_a), .parity_err(pe_a), .frame_err(fe_a),
    .overrun_err(ovr_a), .active_flag(act_a)
  );

  uart_rx_param #(.DATA_W(7), .OS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_b (
    .baud_clk(baud_clk), .reset(reset), .data_tx(tx_b), .data_ready(ready_b),
    .data_parll(data_b), .data_valid(valid_b), .parity_err(pe_b), .frame_err(fe_b),
    .overrun_err(ovr_b), .active_flag(act_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge baud_clk) begin
    if (!reset) begin
      if (ovr_a) ovr_cnt_a++;
      if (valid_a && ready_a) begin
        if (q_a.size() == 0) begin
          check("a_unexpected_word", {24'h0, data_a}, 32'hffff_ffff);
        end else begin
          ea = q_a.pop_front();
          check("a_data", {24'h0, data_a}, {23'h0, ea.d});
          check("a_parity_err", {31'h0, pe_a}, {31'h0, ea.pe});
          check("a_frame_err", {31'h0, fe_a}, {31'h0, ea.fe});
        end
      end
    end
  end

  always @(negedge baud_clk) begin
    if (!reset) begin
      if (ovr_b) ovr_cnt_b++;
      if (valid_b && ready_b) begin
        if (q_b.size() == 0) begin
          check("b_unexpected_word", {25'h0, data_b}, 32'hffff_ffff);
        end else begin
          eb = q_b.pop_front();
          check("b_data", {25'h0, data_b}, {23'h0, eb.d});
          check("b_parity_err", {31'h0, pe_b}, {31'h0, eb.pe});
          check("b_frame_err", {31'h0, fe_b}, {31'h0, eb.fe});
        end
      end
    end
  end

  task automatic drive(input int which, input logic v, input int n);
    if (which == 0) tx_a = v;
    else tx_b = v;
    repeat (n) @(negedge baud_clk);
  endtask

  task automatic send_frame(input int which, input int os, input int nbits, input logic [8:0] d,
                            input logic has_par, input logic p, input int nstop, input logic [1:0] stops);
    drive(which, 1'b0, os);
    for (int i = 0; i < nbits; i++) drive(which, d[i], os);
    if (has_par) drive(which, p, os);
    for (int i = 0; i < nstop; i++) drive(which, stops[i], os);
  endtask

  task automatic push_a(input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe;
    q_a.push_back(e);
  endtask

  task automatic push_b(input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe;
    q_b.push_back(e);
  endtask

  initial begin
    logic act_seen;
    int   t;
    repeat (5) @(negedge baud_clk);
    reset = 1'b0;
    check("reset_valid", {31'h0, valid_a}, 32'h0);
    check("reset_data", {24'h0, data_a}, 32'h0);
    check("reset_errs", {29'h0, pe_a, fe_a, ovr_a}, 32'h0);
    check("reset_active", {31'h0, act_a}, 32'h0);
    check("reset_b_outputs", {26'h0, valid_b, pe_b, fe_b, ovr_b, act_b}, 32'h0);
    drive(0, 1'b1, 20);

    // clean 0xA5, even parity 0
    push_a(9'h0A5, 1'b0, 1'b0);
    send_frame(0, 16, 8, 9'h0A5, 1'b1, 1'b0, 1, 2'b11);
    drive(0, 1'b1, 20);

    // three-cycle glitch must be rejected
    act_seen = 1'b0;
    drive(0, 1'b0, 3);
    tx_a = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge baud_clk);
      act_seen |= act_a;
    end
    check("glitch_no_active", {31'h0, act_seen}, 32'h0);

    // wrong parity bit
    push_a(9'h0A5, 1'b1, 1'b0);
    send_frame(0, 16, 8, 9'h0A5, 1'b1, 1'b1, 1, 2'b11);
    drive(0, 1'b1, 20);

    // stop bit 0 then line held low: break
    push_a(9'h03C, 1'b0, 1'b1);
    send_frame(0, 16, 8, 9'h03C, 1'b1, 1'b0, 1, 2'b00);
    drive(0, 1'b0, 40);
    check("break_inactive", {31'h0, act_a}, 32'h0);
    drive(0, 1'b1, 20);
    push_a(9'h011, 1'b0, 1'b0);
    send_frame(0, 16, 8, 9'h011, 1'b1, 1'b0, 1, 2'b11);
    drive(0, 1'b1, 20);

    // overrun: consumer stalled across two back-to-back frames
    ready_a = 1'b0;
    push_a(9'h03C, 1'b0, 1'b0);
    send_frame(0, 16, 8, 9'h03C, 1'b1, 1'b0, 1, 2'b11);
    send_frame(0, 16, 8, 9'h0C3, 1'b1, 1'b0, 1, 2'b11);
    drive(0, 1'b1, 20);
    check("stall_valid_held", {31'h0, valid_a}, 32'h1);
    check("stall_data_held", {24'h0, data_a}, 32'h3C);
    ready_a = 1'b1;
    drive(0, 1'b1, 5);
    check("overrun_pulses", ovr_cnt_a, 32'd1);

    // 7-bit, odd parity, two stops, OS=8: 0x55 has four ones -> parity bit 1
    drive(1, 1'b1, 10);
    push_b(9'h055, 1'b0, 1'b0);
    send_frame(1, 8, 7, 9'h055, 1'b1, 1'b1, 2, 2'b11);
    drive(1, 1'b1, 16);
    push_b(9'h055, 1'b0, 1'b1);
    send_frame(1, 8, 7, 9'h055, 1'b1, 1'b1, 2, 2'b01);
    drive(1, 1'b1, 30);
    check("b_no_overrun", ovr_cnt_b, 32'd0);

    t = 0;
    while ((q_a.size() + q_b.size()) != 0 && t < 1000) begin
      @(negedge baud_clk);
      t++;
    end
    check("queues_drained", q_a.size() + q_b.size(), 32'd0);
    check("final_valid_clear", {30'h0, valid_a, valid_b}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
